// File: rtl/gray_convert_scheduler.sv
// gray_convert_scheduler
//   Shares one fixed-latency gray-to-binary converter between NREQ requesters.
//   A round-robin arbiter grants at most one request per cycle. The granted
//   gray value is issued to the converter, and the requester id travels
//   alongside it in a tag pipeline. Converted results land in an in-order
//   response FIFO. The converter cannot stall, so a grant is only given while
//   a FIFO slot is reserved for it: the outstanding counter covers results in
//   flight plus results already queued.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   req_valid     per-requester request valid
//   req_ready     per-requester accept (at most one bit high)
//   req_gray      requester i gray value at [i*N +: N]
//   conv_en       converter input valid
//   conv_gray     converter input value
//   conv_binary   converter result, valid CONV_LAT cycles after conv_en
//   rsp_valid     response FIFO head valid
//   rsp_ready     consumer accepts head
//   rsp_id        requester index of head result
//   rsp_binary    converted value of head result
//   busy          any request accepted but not yet popped
module gray_convert_scheduler #(
  parameter int N          = 4,
  parameter int NREQ       = 4,
  parameter int CONV_LAT   = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_gray,
  output logic              conv_en,
  output logic [N-1:0]      conv_gray,
  input  logic [N-1:0]      conv_binary,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_binary,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]  LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [IDW-1:0] LAST_REQ = IDW'(NREQ - 1);

  logic [IDW-1:0]  last_grant;
  logic [CW-1:0]   outstanding;
  logic            grant_ok;
  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [N-1:0]    grant_gray;
  logic [NREQ-1:0] grant_oh;
  logic            accept;
  logic            pop;

  logic            conv_en_q;
  logic [N-1:0]    conv_gray_q;

  logic [CONV_LAT:0] tag_v;
  logic [IDW-1:0]    tag_id [CONV_LAT+1];

  logic [N-1:0]    mem_bin [FIFO_DEPTH];
  logic [IDW-1:0]  mem_id  [FIFO_DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   fifo_count;
  logic            fifo_wr;

  // Credit uses the registered count only; a same-cycle pop frees its slot
  // one cycle later, which keeps this path free of rsp_ready.
  assign grant_ok = (outstanding < DEPTH_C);

  // Round-robin: first pass covers indices above last_grant, second pass
  // wraps to indices at or below it.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_gray  = '0;
    grant_oh    = '0;
    if (!rst && grant_ok) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i] && (IDW'(i) > last_grant)) begin
          grant_found = 1'b1;
          grant_id    = IDW'(i);
          grant_gray  = req_gray[i*N +: N];
          grant_oh[i] = 1'b1;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i] && (IDW'(i) <= last_grant)) begin
          grant_found = 1'b1;
          grant_id    = IDW'(i);
          grant_gray  = req_gray[i*N +: N];
          grant_oh[i] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant_oh;
  assign accept    = grant_found;
  assign fifo_wr   = tag_v[CONV_LAT];
  assign rsp_valid = ~rst & (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= LAST_REQ;
      outstanding <= '0;
      conv_en_q   <= 1'b0;
      conv_gray_q <= '0;
      tag_v       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      fifo_count  <= '0;
    end else begin
      if (accept) begin
        last_grant  <= grant_id;
        conv_gray_q <= grant_gray;
      end
      conv_en_q <= accept;
      tag_v     <= {tag_v[CONV_LAT-1:0], accept};

      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (fifo_wr) wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
      if (pop)     rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);

      case ({fifo_wr, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Ids and FIFO storage need no reset: only the valid bits and counters
  // decide what is visible.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int k = 1; k <= CONV_LAT; k++) tag_id[k] <= tag_id[k-1];
    if (fifo_wr) begin
      mem_bin[wptr] <= conv_binary;
      mem_id[wptr]  <= tag_id[CONV_LAT];
    end
  end

  // Outputs are forced to zero whenever rst is high, including the first
  // reset cycle before the registers have been cleared.
  assign conv_en    = conv_en_q & ~rst;
  assign conv_gray  = rst ? '0 : conv_gray_q;
  assign rsp_id     = rsp_valid ? mem_id[rptr]  : '0;
  assign rsp_binary = rsp_valid ? mem_bin[rptr] : '0;
  assign busy       = ~rst & (outstanding != '0);

endmodule

// File: tb/tb_gray_convert_scheduler.sv
module tb_gray_convert_scheduler;
  localparam int N = 4, NREQ = 4, LAT = 2, DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_gray;
  logic              conv_en;
  logic [N-1:0]      conv_gray, conv_binary;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_binary;
  logic              busy;

  gray_convert_scheduler #(.N(N), .NREQ(NREQ), .CONV_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_gray(req_gray),
    .conv_en(conv_en), .conv_gray(conv_gray), .conv_binary(conv_binary),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_binary(rsp_binary),
    .busy(busy));

  // DUT B: single requester, latency 1, depth 4
  logic         b_rst;
  logic [0:0]   b_req_valid, b_req_ready;
  logic [N-1:0] b_req_gray;
  logic         b_conv_en;
  logic [N-1:0] b_conv_gray, b_conv_binary;
  logic         b_rsp_valid, b_rsp_ready;
  logic [0:0]   b_rsp_id;
  logic [N-1:0] b_rsp_binary;
  logic         b_busy;

  gray_convert_scheduler #(.N(N), .NREQ(1), .CONV_LAT(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_gray(b_req_gray),
    .conv_en(b_conv_en), .conv_gray(b_conv_gray), .conv_binary(b_conv_binary),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_binary(b_rsp_binary),
    .busy(b_busy));

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  // Converter models: pure delay lines of the gray-to-binary function
  logic [N-1:0] cpipe [LAT];
  logic [N-1:0] b_cpipe;
  always @(posedge clk) begin
    cpipe[0] <= conv_gray;
    for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
    b_cpipe <= b_conv_gray;
  end
  assign conv_binary   = g2b(cpipe[LAT-1]);
  assign b_conv_binary = g2b(b_cpipe);

  // Transaction-level reference model
  typedef struct { int id; logic [N-1:0] bin; int vis; } rsp_t;
  rsp_t rspq[$];
  rsp_t bq[$];
  int mcyc, m_last, m_out;
  logic m_conv_en;
  logic [N-1:0] m_conv_gray;

  int exp_grant, exp_id;
  logic [NREQ-1:0] exp_ready;
  logic exp_rsp_valid, exp_pop, exp_busy, exp_conv_en;
  logic [N-1:0] exp_bin, exp_conv_gray;

  logic [NREQ-1:0] hold_valid;
  logic [N-1:0]    hold_gray [NREQ];

  int tests = 0;
  int fails = 0;

  task automatic model_eval();
    exp_grant = -1;
    if (!rst && m_out < DEPTH)
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (exp_grant < 0 && req_valid[i]) exp_grant = i;
      end
    exp_ready     = (exp_grant >= 0) ? (NREQ'(1) << exp_grant) : '0;
    exp_rsp_valid = !rst && rspq.size() > 0 && rspq[0].vis <= mcyc;
    exp_id        = exp_rsp_valid ? rspq[0].id : 0;
    exp_bin       = exp_rsp_valid ? rspq[0].bin : '0;
    exp_pop       = exp_rsp_valid && rsp_ready;
    exp_busy      = !rst && m_out != 0;
    exp_conv_en   = !rst && m_conv_en;
    exp_conv_gray = rst ? '0 : m_conv_gray;
  endtask

  task automatic model_commit();
    if (rst) begin
      rspq.delete();
      m_out = 0; m_last = NREQ - 1; m_conv_en = 1'b0; m_conv_gray = '0;
    end else begin
      if (exp_grant >= 0) begin
        rsp_t e;
        e.id = exp_grant;
        e.bin = g2b(req_gray[exp_grant*N +: N]);
        e.vis = mcyc + LAT + 2;
        rspq.push_back(e);
        m_conv_gray = req_gray[exp_grant*N +: N];
        m_last = exp_grant;
        m_conv_en = 1'b1;
        m_out++;
      end else begin
        m_conv_en = 1'b0;
      end
      if (exp_pop) begin
        void'(rspq.pop_front());
        m_out--;
      end
    end
    mcyc++;
  endtask

  task automatic step_begin();
    @(negedge clk);
    model_eval();
  endtask

  task automatic step_end();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drive_reqs();
    req_valid = hold_valid;
    for (int i = 0; i < NREQ; i++) req_gray[i*N +: N] = hold_gray[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin step_begin(); step_end(); end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_gray = NREQ*N'($urandom); rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step_begin();
      tests++;
      if ({req_ready, conv_en, conv_gray, rsp_valid, rsp_id, rsp_binary, busy} !== '0) begin
        fails++;
        $display("FAIL reset_outputs cyc=%0d got rdy=%b en=%b g=%h rv=%b id=%0d bin=%h busy=%b required all 0",
                 c, req_ready, conv_en, conv_gray, rsp_valid, rsp_id, rsp_binary, busy);
      end
      step_end();
    end
    rst = 1'b0; req_valid = '0;
    step_begin();
    tests++;
    if ({rsp_valid, busy, conv_en} !== 3'b000) begin
      fails++;
      $display("FAIL reset_release got rv=%b busy=%b en=%b required 000", rsp_valid, busy, conv_en);
    end
    step_end();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_valid = (k == 0) ? 4'b0100 : 4'b0000;
      req_gray = '0;
      req_gray[2*N +: N] = 4'b1101;
      step_begin();
      tests++;
      case (k)
        0: if (req_ready !== 4'b0100) begin
             fails++; $display("FAIL single_grant got %b required 0100", req_ready);
           end
        1: if ({conv_en, conv_gray, busy} !== {1'b1, 4'b1101, 1'b1}) begin
             fails++; $display("FAIL single_issue got en=%b g=%b busy=%b required 1 1101 1", conv_en, conv_gray, busy);
           end
        2: if ({conv_en, conv_gray, rsp_valid} !== {1'b0, 4'b1101, 1'b0}) begin
             fails++; $display("FAIL single_hold got en=%b g=%b rv=%b required 0 1101 0", conv_en, conv_gray, rsp_valid);
           end
        3: if (rsp_valid !== 1'b0) begin
             fails++; $display("FAIL single_early got rv=%b required 0", rsp_valid);
           end
        4: if ({rsp_valid, rsp_id, rsp_binary} !== {1'b1, 2'd2, 4'b1001}) begin
             fails++; $display("FAIL single_rsp got rv=%b id=%0d bin=%b required 1 2 1001", rsp_valid, rsp_id, rsp_binary);
           end
        default: if ({rsp_valid, busy} !== 2'b00) begin
             fails++; $display("FAIL single_idle got rv=%b busy=%b required 00", rsp_valid, busy);
           end
      endcase
      step_end();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    hold_valid = '1;
    for (int i = 0; i < NREQ; i++) hold_gray[i] = N'($urandom);
    rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive_reqs();
      step_begin();
      tests++;
      if (req_ready !== exp_ready || (c == 0 && req_ready !== 4'b0001)) begin
        fails++; $display("FAIL rr_ready cyc=%0d got %b required %b", c, req_ready, exp_ready);
      end
      tests++;
      if (rsp_valid !== exp_rsp_valid) begin
        fails++; $display("FAIL rr_rsp_valid cyc=%0d got %b required %b", c, rsp_valid, exp_rsp_valid);
      end else if (exp_rsp_valid) begin
        tests++;
        if (rsp_id !== 2'(exp_id) || rsp_binary !== exp_bin) begin
          fails++; $display("FAIL rr_rsp cyc=%0d got id=%0d bin=%h required id=%0d bin=%h", c, rsp_id, rsp_binary, exp_id, exp_bin);
        end
      end
      step_end();
      if (exp_grant >= 0) hold_gray[exp_grant] = N'($urandom);
    end
  endtask

  task automatic test_alternate();
    int prev_g;
    prev_g = -1;
    hold_valid = 4'b1010;
    rsp_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      drive_reqs();
      step_begin();
      tests++;
      if (req_ready !== exp_ready || (req_ready & 4'b0101) != 4'b0000) begin
        fails++; $display("FAIL alt_ready cyc=%0d got %b required %b", c, req_ready, exp_ready);
      end
      if (exp_grant >= 0 && prev_g >= 0) begin
        tests++;
        if (exp_grant == prev_g || req_ready == NREQ'(1 << prev_g)) begin
          fails++; $display("FAIL alt_order cyc=%0d got %b previous grant %0d", c, req_ready, prev_g);
        end
      end
      tests++;
      if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid && (rsp_id !== 2'(exp_id) || rsp_binary !== exp_bin))) begin
        fails++; $display("FAIL alt_rsp cyc=%0d got rv=%b id=%0d bin=%h required rv=%b id=%0d bin=%h",
                          c, rsp_valid, rsp_id, rsp_binary, exp_rsp_valid, exp_id, exp_bin);
      end
      if (exp_grant >= 0) prev_g = exp_grant;
      step_end();
      if (exp_grant >= 0) hold_gray[exp_grant] = N'($urandom);
    end
  endtask

  task automatic test_backpressure();
    int acc, first_pop, first_acc;
    acc = 0; first_pop = -1; first_acc = -1;
    do_reset();
    hold_valid = 4'b0001;
    hold_gray[0] = N'($urandom);
    rsp_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      drive_reqs();
      step_begin();
      if (req_ready[0] && req_valid[0]) acc++;
      tests++;
      if (req_ready !== exp_ready) begin
        fails++; $display("FAIL bp_fill_ready cyc=%0d got %b required %b", c, req_ready, exp_ready);
      end
      step_end();
      if (exp_grant >= 0) hold_gray[0] = N'($urandom);
    end
    tests++;
    if (acc != 8 || busy !== 1'b1) begin
      fails++; $display("FAIL bp_accepts got %0d busy=%b required 8 busy=1", acc, busy);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 16) hold_valid = '0;
      drive_reqs();
      step_begin();
      if (first_pop < 0 && rsp_valid && rsp_ready) first_pop = c;
      if (first_acc < 0 && (req_ready & req_valid) != 0) first_acc = c;
      tests++;
      if (req_ready !== exp_ready) begin
        fails++; $display("FAIL bp_drain_ready cyc=%0d got %b required %b", c, req_ready, exp_ready);
      end
      tests++;
      if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid && (rsp_id !== 2'(exp_id) || rsp_binary !== exp_bin))) begin
        fails++; $display("FAIL bp_rsp cyc=%0d got rv=%b id=%0d bin=%h required rv=%b id=%0d bin=%h",
                          c, rsp_valid, rsp_id, rsp_binary, exp_rsp_valid, exp_id, exp_bin);
      end
      step_end();
      if (exp_grant >= 0) hold_gray[0] = N'($urandom);
    end
    tests++;
    if (first_pop != 0 || first_acc != first_pop + 1) begin
      fails++; $display("FAIL bp_resume got pop=%0d acc=%0d required pop=0 acc=1", first_pop, first_acc);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    hold_valid = 4'b0001;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      hold_gray[0] = N'($urandom);
      drive_reqs();
      step_begin();
      tests++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rsp_valid) begin
        fails++; $display("FAIL mid_fill cyc=%0d got rdy=%b rv=%b required rdy=%b rv=%b", c, req_ready, rsp_valid, exp_ready, exp_rsp_valid);
      end
      step_end();
    end
    hold_valid = '0; drive_reqs();
    rst = 1'b1;
    step_begin();
    tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      fails++; $display("FAIL mid_rst got rv=%b busy=%b required 00", rsp_valid, busy);
    end
    step_end();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step_begin();
      tests++;
      if ({rsp_valid, busy} !== 2'b00 || rsp_valid !== exp_rsp_valid) begin
        fails++; $display("FAIL mid_after cyc=%0d got rv=%b busy=%b required 00", c, rsp_valid, busy);
      end
      step_end();
    end
    hold_valid = 4'b1100;
    hold_gray[2] = N'($urandom); hold_gray[3] = N'($urandom);
    drive_reqs();
    step_begin();
    tests++;
    if (req_ready !== 4'b0100 || exp_ready !== 4'b0100) begin
      fails++; $display("FAIL mid_first_grant got %b required 0100", req_ready);
    end
    step_end();
    hold_valid = '0; drive_reqs();
    repeat (8) begin step_begin(); step_end(); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      hold_valid[i] = 1'($urandom_range(0, 1));
      hold_gray[i] = N'($urandom);
    end
    for (int c = 0; c < 300; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      drive_reqs();
      step_begin();
      tests++;
      if (req_ready !== exp_ready) begin
        fails++; $display("FAIL rnd_ready cyc=%0d got %b required %b", c, req_ready, exp_ready);
      end
      tests++;
      if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid && (rsp_id !== 2'(exp_id) || rsp_binary !== exp_bin))) begin
        fails++; $display("FAIL rnd_rsp cyc=%0d got rv=%b id=%0d bin=%h required rv=%b id=%0d bin=%h",
                          c, rsp_valid, rsp_id, rsp_binary, exp_rsp_valid, exp_id, exp_bin);
      end
      tests++;
      if (conv_en !== exp_conv_en || conv_gray !== exp_conv_gray || busy !== exp_busy) begin
        fails++; $display("FAIL rnd_issue cyc=%0d got en=%b g=%h busy=%b required en=%b g=%h busy=%b",
                          c, conv_en, conv_gray, busy, exp_conv_en, exp_conv_gray, exp_busy);
      end
      step_end();
      for (int i = 0; i < NREQ; i++) begin
        if (i == exp_grant) begin
          hold_valid[i] = 1'($urandom_range(0, 1));
          hold_gray[i] = N'($urandom);
        end else if (!hold_valid[i] && $urandom_range(0, 2) == 0) begin
          hold_valid[i] = 1'b1;
          hold_gray[i] = N'($urandom);
        end
      end
    end
  endtask

  task automatic test_nreq1();
    int nresp, gseq;
    logic acc;
    nresp = 0; gseq = 0;
    rst = 1'b1; req_valid = '0;
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    b_req_gray = '0;
    @(posedge clk); #1;
    b_rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      rsp_t e;
      logic ev;
      @(negedge clk);
      ev = (bq.size() > 0) && (bq[0].vis <= c);
      tests++;
      if (b_req_ready !== 1'b1) begin
        fails++; $display("FAIL n1_ready cyc=%0d got %b required 1", c, b_req_ready);
      end
      tests++;
      if (b_rsp_valid !== ev) begin
        fails++; $display("FAIL n1_rsp_valid cyc=%0d got %b required %b", c, b_rsp_valid, ev);
      end else if (ev) begin
        tests++;
        if (b_rsp_id !== 1'b0 || b_rsp_binary !== bq[0].bin) begin
          fails++; $display("FAIL n1_rsp cyc=%0d got id=%0d bin=%h required id=0 bin=%h", c, b_rsp_id, b_rsp_binary, bq[0].bin);
        end
        void'(bq.pop_front());
        nresp++;
      end
      acc = b_req_valid[0] && b_req_ready[0];
      if (acc) begin
        e.id = 0; e.bin = g2b(b_req_gray); e.vis = c + 3;
        bq.push_back(e);
      end
      @(posedge clk); #1;
      if (acc) begin
        gseq++;
        b_req_gray = N'(gseq);
      end
    end
    tests++;
    if (nresp < 16) begin
      fails++; $display("FAIL n1_count got %0d responses required at least 16", nresp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_gray = '0; rsp_ready = 1'b0;
    b_rst = 1'b1; b_req_valid = '0; b_req_gray = '0; b_rsp_ready = 1'b0;
    mcyc = 0; m_last = NREQ - 1; m_out = 0; m_conv_en = 1'b0; m_conv_gray = '0;
    hold_valid = '0;
    for (int i = 0; i < NREQ; i++) hold_gray[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_alternate();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_nreq1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_convert_scheduler.md
Name: gray_convert_scheduler

Overview:
Shares one fixed-latency gray-to-binary converter pipeline between NREQ requesters. Each cycle it grants at most one request using round-robin arbitration. It drives the converter input, tracks each in-flight request's requester ID through a tag pipeline, and buffers results in an in-order response FIFO with valid/ready backpressure. The converter cannot stall, so issue is credit-limited by free FIFO space.

Parameters:
N, 4, gray/binary data width
NREQ, 4, number of requesters (>=1)
CONV_LAT, 2, converter latency in cycles, conv_en cycle to conv_binary valid cycle (>=1)
FIFO_DEPTH, 8, response FIFO entries; full throughput requires FIFO_DEPTH >= CONV_LAT+3

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, at most one bit high
req_gray  in  NREQ*N  requester i gray value at [i*N +: N]
conv_en  out  1  converter input valid
conv_gray  out  N  converter input value
conv_binary  in  N  converter output, valid CONV_LAT cycles after conv_en
rsp_valid  out  1  response FIFO head valid
rsp_ready  in  1  consumer accept
rsp_id  out  max(1,$clog2(NREQ))  requester index of head result
rsp_binary  out  N  converted value of head result
busy  out  1  high when outstanding != 0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: conv_en=0, conv_gray=0, rsp_valid=0, rsp_id=0, rsp_binary=0, busy=0, req_ready=0 in every cycle rst is high.
- Reset clears the tag pipeline valids, empties the FIFO, sets outstanding=0 and sets last_grant=NREQ-1, so requester 0 has first priority.
- Reset mid-operation drops all in-flight requests. Converter outputs that arrive after reset produce no response.
- Credit: outstanding is a registered counter of width $clog2(FIFO_DEPTH+1).
  - It increments on accept and decrements on pop; if both happen in one cycle, it is unchanged.
  - grant_ok = (outstanding < FIFO_DEPTH), computed from the registered value only.
  - A pop in the same cycle does not free a credit until the next cycle.
- Arbitration: when grant_ok, req_ready is one-hot on the first requester i with req_valid[i]=1, searching from last_grant+1 with wrap at NREQ.
  - req_ready is combinational from req_valid and state.
  - Accept means req_valid[i] && req_ready[i].
  - On accept, last_grant <= i; otherwise last_grant holds.
  - A requester must hold req_valid and req_gray stable until accepted.
- Issue: accept in cycle t causes conv_en=1 and conv_gray=req_gray[i] (registered) in cycle t+1.
  - With no accept, the next cycle has conv_en=0 and conv_gray holds its previous value.
- Tag pipeline: a CONV_LAT+1 stage shift register of {valid,id} aligned with conv_en.
  - The tail stage is valid exactly in cycle t+1+CONV_LAT.
  - In that cycle conv_binary and the tail id are written into the FIFO at the clock edge.
- Response: rsp_valid, rsp_id and rsp_binary come from the registered FIFO head.
  - Earliest rsp_valid is cycle t+2+CONV_LAT, i.e. minimum accept-to-response latency of CONV_LAT+2.
  - Pop occurs on rsp_valid && rsp_ready.
  - While stalled, head outputs hold stable.
  - Responses leave in accept order.
- FIFO boundaries: credit guarantees a write never targets a full FIFO, including simultaneous write+pop when full.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous write and pop is legal at any fill level.
  - On an empty FIFO a write is never bypassed, so rsp_valid rises the cycle after the write.
- Throughput: one accept per cycle sustained when rsp_ready=1 and FIFO_DEPTH >= CONV_LAT+3.

Test Plan:
- Single request, defaults; the bench models the converter as a CONV_LAT=2 delay of a gray-to-binary function. Requester 2 sends 4'b1101 at cycle t -> conv_en=1 and conv_gray=1101 at t+1; rsp_valid at t+4 with rsp_id=2 and rsp_binary=4'b1001; busy low after the pop.
- All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; responses every cycle in the same ID order; no cycle with req_ready=0 after the first.
- Requesters 1 and 3 held valid, others idle -> grants strictly alternate 1,3,1,3; requesters 0 and 2 never granted.
- rsp_ready=0, requester 0 held valid -> exactly 8 accepts, then req_ready=0 with outstanding=8. Raise rsp_ready -> 8 responses in order with correct values, and accepts resume one cycle after the first pop.
- rst pulsed one cycle with 3 requests in flight and 2 in the FIFO -> next cycle rsp_valid=0 and busy=0; later conv_binary activity yields no response; the first post-reset grant goes to the lowest-index valid requester.
- NREQ=1, CONV_LAT=1, FIFO_DEPTH=4, continuous traffic -> rsp_id always 0; every gray value 0..15 returns its correct binary value; latency 3; sustained 1 accept per cycle.
